// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART transmit engine: frame-sequencing FSM, LSB-first serializer, parity
//   generator, bit-period counter and registered output in a single block.
//   A word is accepted while idle, or in the final cycle of the last stop bit
//   so that frames can follow back to back with no idle gap.
//
// Ports
//   CLK        in   UART clock
//   RST        in   synchronous active-high reset
//   P_DATA     in   parallel word to send (DATA_WIDTH bits)
//   Data_Valid in   send request, single-cycle or held
//   PAR_EN     in   1 = append a parity bit
//   PAR_TYP    in   0 = even parity, 1 = odd parity
//   STOP2      in   1 = two stop bits, 0 = one
//   TX_OUT     out  registered serial line, idle high
//   busy       out  registered, high while a frame is on the line
//   done       out  registered pulse in the final cycle of the last stop bit

module uart_tx_engine #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    output logic                  TX_OUT,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    tx_state_t             state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
    logic                  par_bit_q,  par_bit_d;
    logic                  par_en_q,   par_en_d;
    logic                  stop2_q,    stop2_d;
    logic                  stop_idx_q, stop_idx_d;
    logic                  tx_out_q,   tx_out_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic bit_end;
    logic last_stop;
    logic accept;

    assign bit_end   = (cnt_q == CNT_LAST);
    // The last stop bit is stop index 0 for one stop bit, index 1 for two.
    assign last_stop = (state_q == STOP) && bit_end && (stop_idx_q == stop2_q);
    assign accept    = Data_Valid && ((state_q == IDLE) || last_stop);

    // Next-state logic. The registered outputs are derived from the *next*
    // state so that TX_OUT/busy/done change on the same edge as the state,
    // giving a start bit on the cycle right after the accepting edge.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_bit_d  = par_bit_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        cnt_d      = (state_q == IDLE || bit_end) ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            IDLE: begin
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d    = par_en_q ? PARITY : STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d    = STOP;
                    stop_idx_d = 1'b0;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == stop2_q) begin
                        state_d = IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Acceptance overrides the normal sequencing; it only fires in IDLE
        // or in the final stop cycle, so a request mid-frame is dropped.
        if (accept) begin
            state_d    = START;
            cnt_d      = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            shift_d    = P_DATA;
            par_bit_d  = (^P_DATA) ^ PAR_TYP;
            par_en_d   = PAR_EN;
            stop2_d    = STOP2;
        end

        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            PARITY:  tx_out_d = par_bit_d;
            default: tx_out_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (stop_idx_d == stop2_d) && (cnt_d == CNT_LAST);
    end

    // State and output registers; reset aborts any frame and idles the line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            par_bit_q  <= par_bit_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign TX_OUT = tx_out_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
Parametrised UART transmit engine that integrates the frame-sequencing FSM, serializer, parity generator, bit-period counter and output mux in one block. It accepts a parallel word with a valid strobe, then shifts out start, data (LSB first), optional even/odd parity and one or two stop bits. It supports back-to-back frames with no idle gap. It sits in the UART TX path between the synchronised data source and the serial TX pin, clocked by the UART clock domain.

Parameters:
DATA_WIDTH, 8, data bits per frame (5..9).
CLKS_PER_BIT, 1, CLK cycles per serial bit (1..16); 1 means CLK is the baud clock.

Ports:
CLK  input  1  UART clock.
RST  input  1  reset, synchronous, active-high.
P_DATA  input  DATA_WIDTH  parallel data to send.
Data_Valid  input  1  request to send P_DATA; single-cycle or held.
PAR_EN  input  1  1 = append parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
STOP2  input  1  1 = two stop bits, 0 = one.
TX_OUT  output  1  serial line, registered, idle high.
busy  output  1  registered; high while a frame is in progress.
done  output  1  registered one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset:
  - Active on a CLK edge with RST=1. Forces state IDLE, TX_OUT=1, busy=0, done=0, and clears all counters and shift registers.
  - Reset mid-frame aborts the frame. TX_OUT is 1 from the following cycle. No done pulse is produced.
- States: IDLE, START, DATA, PARITY, STOP. TX_OUT is driven from registered state and data, with no combinational path from inputs.
- Acceptance: Data_Valid is sampled at a CLK edge while in IDLE, or in the final cycle of the last stop bit.
  - On acceptance, P_DATA, PAR_EN, PAR_TYP and STOP2 are latched.
  - Parity is computed from latched data: even = XOR of all bits; odd = inverted XOR.
  - Input changes after acceptance do not affect the frame in flight.
- Data_Valid at any other time while busy is ignored. There is no queueing.
- Bit timing: each bit lasts exactly CLKS_PER_BIT cycles, counted by a bit-period counter that wraps to 0 at CLKS_PER_BIT-1.
- Latency: the first start-bit cycle (TX_OUT=0) appears on the cycle after the acceptance edge. busy=1 from that same cycle.
- Sequence:
  - START: 1 bit of 0.
  - DATA: DATA_WIDTH bits, LSB first. A bit index counter runs 0..DATA_WIDTH-1.
  - PARITY: 1 bit, only if PAR_EN was latched as 1.
  - STOP: 1 or 2 bits of 1, per latched STOP2.
- Frame length in CLK cycles: (1+DATA_WIDTH+PAR_EN+1+STOP2)*CLKS_PER_BIT.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA when the bit period ends.
  - DATA -> PARITY or STOP after the last data bit.
  - PARITY -> STOP.
  - STOP -> START if accepted in its final cycle, otherwise IDLE.
- busy: falls to 0 on the cycle after the last stop-bit cycle, unless a back-to-back accept occurred, in which case it stays 1 continuously.
- done: a one-cycle pulse, high during the final cycle of the last stop bit.
- Idle: TX_OUT=1, busy=0, done=0.
- Simultaneous RST and Data_Valid: reset wins and the request is dropped.

Test Plan:
- DATA_WIDTH=8, CLKS_PER_BIT=1, P_DATA=0xA5, PAR_EN=0, STOP2=0, 1-cycle Data_Valid -> TX_OUT=0,1,0,1,0,0,1,0,1,1 over 10 cycles starting the cycle after the strobe. busy high for 10 cycles. done high in cycle 10.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0, 11-bit frame. Repeat with PAR_TYP=1 -> parity bit 1.
- P_DATA=0x01, PAR_EN=1, PAR_TYP=0, STOP2=1 -> parity 1, two stop bits, 12-cycle frame, done in the last stop cycle.
- Back-to-back: Data_Valid asserted in the final stop cycle with 0x3C -> start bit immediately follows, busy never drops. Data_Valid pulsed mid-frame with 0xFF -> ignored, and the line goes idle after the first frame.
- CLKS_PER_BIT=4, P_DATA=0x55, no parity -> each bit held exactly 4 cycles, 40-cycle frame.
- RST asserted during data bit 3 -> next cycle TX_OUT=1, busy=0, no done pulse. A new Data_Valid after reset yields a clean full frame.
